// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache request ports and single-ported RAM bus seen by mem_arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN, iwait;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] iload;
  logic              dREN, dWEN, dwait;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore, dload;
  logic              ramREN, ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore, ramload;
  logic [1:0]        ramstate;
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: fair instruction/data arbiter driving a single-ported RAM with error and timeout handling
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic           CLK,
  input  logic           nRST,
  mem_arbiter_if.slave   bus,
  output logic           err,
  output logic           busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;
  state_t            state, next;
  logic              last_d, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [CW-1:0]     cnt;
  logic              dreq, own, acc, fail, done, grant_d;
  assign dreq    = bus.dREN | bus.dWEN;
  assign own     = state == DGRANT ? dreq : state == IGRANT ? bus.iREN : 1'b0;
  assign acc     = own && bus.ramstate == 2'd2;
  assign fail    = own && !acc && (bus.ramstate == 2'd3 || cnt == CW'(TIMEOUT - 1));
  assign done    = acc | fail;
  assign grant_d = dreq && (!bus.iREN || !last_d);
  assign busy         = state != IDLE;
  assign bus.ramREN   = busy && !wr_q;
  assign bus.ramWEN   = busy && wr_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = data_q;
  assign bus.dwait    = !(state == DGRANT && done);
  assign bus.iwait    = !(state == IGRANT && done);
  assign bus.dload    = (state == DGRANT && acc && !wr_q) ? bus.ramload : '0;
  assign bus.iload    = (state == IGRANT && acc) ? bus.ramload : '0;
  always_comb begin
    next = state;
    if (state == IDLE) next = grant_d ? DGRANT : bus.iREN ? IGRANT : IDLE;
    else if (!own || done) next = IDLE;
  end
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      last_d <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      state <= next;
      err   <= err | fail;
      cnt   <= (state == IDLE || next == IDLE) ? '0 : cnt + CW'(1);
      if (acc) last_d <= state == DGRANT;
      if (state == IDLE && grant_d) begin
        addr_q <= bus.daddr;
        data_q <= bus.dstore;
        wr_q   <= bus.dWEN;
      end else if (state == IDLE && bus.iREN) begin
        addr_q <= bus.iaddr;
        wr_q   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven transactions with a completion scoreboard plus corner-case sequences
module tb_mem_arbiter;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic err, busy;
  int total = 0;
  int bad = 0;
  always #5 CLK = ~CLK;
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus), .err(err), .busy(busy)
  );
  typedef struct {
    bit          rst;
    bit          is_d;
    bit          wr;
    bit          both;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rload;
    int          n;
    logic [1:0]  fin;
    logic [31:0] exp_load;
    bit          exp_err;
  } vec_t;
  typedef struct {
    bit          is_d;
    logic [31:0] load;
  } exp_t;
  exp_t sbq[$];
  vec_t v[9];
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endfunction
  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask
  task automatic check_done();
    exp_t e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL sb_underflow: got empty queue want entry at %0t", $time);
    end else begin
      e = sbq.pop_front();
      chk("own_wait", e.is_d ? bus.dwait : bus.iwait, 0);
      chk("own_load", e.is_d ? bus.dload : bus.iload, e.load);
      chk("other_wait", e.is_d ? bus.iwait : bus.dwait, 1);
      chk("other_load", e.is_d ? bus.iload : bus.dload, 0);
    end
  endtask
  task automatic run_vec(input vec_t x);
    exp_t e;
    if (x.rst) begin
      nRST = 1'b0;
      #3;
      nRST = 1'b1;
      cyc();
    end
    bus.ramstate = 2'd0;
    bus.ramload  = x.rload;
    if (x.is_d) begin
      bus.dWEN   = x.wr;
      bus.dREN   = !x.wr || x.both;
      bus.daddr  = x.addr;
      bus.dstore = x.wdata;
    end else begin
      bus.iREN  = 1'b1;
      bus.iaddr = x.addr;
    end
    e.is_d = x.is_d;
    e.load = x.exp_load;
    sbq.push_back(e);
    cyc();
    bus.iaddr  = ~x.addr;
    bus.daddr  = ~x.addr;
    bus.dstore = ~x.wdata;
    for (int k = 0; k < x.n; k++) begin
      bus.ramstate = (k == x.n - 1) ? x.fin : 2'd1;
      #1;
      chk("busy", busy, 1);
      chk("ramREN", bus.ramREN, !x.wr);
      chk("ramWEN", bus.ramWEN, x.wr);
      chk("ramaddr", bus.ramaddr, x.addr);
      if (x.wr) chk("ramstore", bus.ramstore, x.wdata);
      if (k < x.n - 1) begin
        chk("iwait_hold", bus.iwait, 1);
        chk("dwait_hold", bus.dwait, 1);
        chk("iload_zero", bus.iload, 0);
        chk("dload_zero", bus.dload, 0);
      end else check_done();
      cyc();
    end
    bus.ramstate = 2'd0;
    #1;
    chk("busy_after", busy, 0);
    chk("ramREN_after", bus.ramREN, 0);
    chk("ramWEN_after", bus.ramWEN, 0);
    chk("iwait_after", bus.iwait, 1);
    chk("dwait_after", bus.dwait, 1);
    chk("err_after", err, x.exp_err);
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
  endtask
  initial begin
    exp_t e;
    v[0] = '{0, 0, 0, 0, 32'h0000_0040, 32'h0, 32'h2002_0001, 3, 2'd2, 32'h2002_0001, 0};
    v[1] = '{0, 1, 1, 0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1234_5678, 2, 2'd2, 32'h0, 0};
    v[2] = '{0, 1, 0, 0, 32'h0000_0200, 32'h0, 32'hCAFE_0002, 1, 2'd2, 32'hCAFE_0002, 0};
    v[3] = '{0, 0, 0, 0, 32'h0000_0048, 32'h0, 32'h1111_1111, 4, 2'd1, 32'h0, 1};
    v[4] = '{0, 0, 0, 0, 32'h0000_0044, 32'h0, 32'h0BAD_F00D, 1, 2'd2, 32'h0BAD_F00D, 1};
    v[5] = '{1, 1, 0, 0, 32'h0000_0300, 32'h0, 32'h5555_5555, 2, 2'd3, 32'h0, 1};
    v[6] = '{0, 1, 1, 0, 32'h0000_0108, 32'hA5A5_0F0F, 32'h0, 1, 2'd2, 32'h0, 1};
    v[7] = '{0, 1, 0, 0, 32'h0000_010C, 32'h0, 32'h7654_3210, 3, 2'd2, 32'h7654_3210, 1};
    v[8] = '{0, 1, 1, 1, 32'h0000_0110, 32'h0F0F_1234, 32'h9999_9999, 2, 2'd2, 32'h0, 1};
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.ramload = 32'hFFFF_FFFF; bus.ramstate = 0;
    #3;
    chk("rst_iwait", bus.iwait, 1);
    chk("rst_dwait", bus.dwait, 1);
    chk("rst_iload", bus.iload, 0);
    chk("rst_dload", bus.dload, 0);
    chk("rst_ramREN", bus.ramREN, 0);
    chk("rst_ramWEN", bus.ramWEN, 0);
    chk("rst_ramaddr", bus.ramaddr, 0);
    chk("rst_ramstore", bus.ramstore, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    #4;
    nRST = 1'b1;
    cyc();
    for (int i = 0; i < 9; i++) run_vec(v[i]);
    bus.iREN = 1'b1;
    bus.iaddr = 32'h80;
    cyc();
    bus.ramstate = 2'd1;
    #1;
    chk("midrst_busy_pre", busy, 1);
    nRST = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ramREN", bus.ramREN, 0);
    chk("midrst_ramaddr", bus.ramaddr, 0);
    chk("midrst_ramstore", bus.ramstore, 0);
    chk("midrst_iwait", bus.iwait, 1);
    chk("midrst_err", err, 0);
    bus.iREN = 1'b0;
    bus.ramstate = 2'd0;
    cyc();
    nRST = 1'b1;
    cyc();
    bus.iREN = 1'b1;
    bus.dREN = 1'b1;
    bus.iaddr = 32'h500;
    bus.daddr = 32'h600;
    for (int r = 0; r < 4; r++) begin
      e.is_d = (r % 2) == 0;
      e.load = 32'hA000_0000 + r;
      sbq.push_back(e);
      cyc();
      bus.ramstate = 2'd2;
      bus.ramload = 32'hA000_0000 + r;
      #1;
      chk("fair_ramaddr", bus.ramaddr, e.is_d ? 32'h600 : 32'h500);
      check_done();
      cyc();
      bus.ramstate = 2'd0;
      #1;
      chk("fair_idle", busy, 0);
    end
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    bus.daddr = 32'h700;
    bus.dREN = 1'b1;
    cyc();
    bus.ramstate = 2'd1;
    #1;
    chk("abort_ramREN_pre", bus.ramREN, 1);
    bus.dREN = 1'b0;
    #1;
    chk("abort_dwait", bus.dwait, 1);
    chk("abort_dload", bus.dload, 0);
    cyc();
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ramREN", bus.ramREN, 0);
    chk("abort_dwait_after", bus.dwait, 1);
    chk("abort_err", err, 0);
    bus.ramstate = 2'd0;
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Memory-side responder for the cache-control request interface.
- Accepts instruction fetches (iREN/iaddr) from the instruction cache and data reads/writes (dREN/dWEN/daddr/dstore) from the data cache.
- Arbitrates between them, drives the single-ported RAM, and returns completion via iwait/dwait with iload/dload.
- Registered grant FSM with fairness, RAM error handling and a transaction timeout.

Parameters:
- ADDR_W, 32, address width of both request ports and ramaddr.
- DATA_W, 32, data word width.
- TIMEOUT, 255, maximum cycles a granted transaction may wait for RAM ACCESS before being aborted.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  instruction read request
- iaddr  in  ADDR_W  instruction address
- iwait  out  1  low for exactly the completing cycle of an instruction read
- iload  out  DATA_W  instruction data, valid when iwait low
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  write data
- dwait  out  1  low for exactly the completing cycle of a data access
- dload  out  DATA_W  read data, valid when dwait low
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- err  out  1  sticky error flag (RAM ERROR or timeout)
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values (asynchronous):
  - state IDLE; iwait=dwait=1; iload=dload=0.
  - ramREN=ramWEN=0; ramaddr=ramstore=0.
  - err=0; busy=0; timeout counter=0; last_grant=INSTR.
- States: IDLE, DGRANT, IGRANT.
- IDLE:
  - No RAM strobes; both waits high.
  - If (dREN|dWEN) and iREN are both asserted: grant the side opposite last_grant.
  - Otherwise grant whichever side requests.
  - On grant, latch op (dWEN has priority over dREN when both are high), address and dstore into registers; next state DGRANT or IGRANT. This gives one cycle of arbitration latency.
- DGRANT / IGRANT:
  - ramaddr = latched address; ramstore = latched data; ramWEN / ramREN per latched op.
  - Counter increments each cycle.
- Completion: ramstate==ACCESS and the owning request is still asserted.
  - Drop the owning wait for that cycle (combinational on ramstate).
  - Drive dload/iload = ramload (reads only).
  - Set last_grant to the owner; next state IDLE; counter cleared.
- ramstate==ERROR:
  - Owning wait drops for one cycle; load output = 0; err set.
  - Next state IDLE.
- Timeout (counter reaches TIMEOUT):
  - Same action as ERROR.
- Requester deasserts its request mid-grant:
  - Abort: strobes drop the next cycle, no wait pulse, next state IDLE, err not set.
- Load outputs are 0 whenever the corresponding wait is high.
- The non-granted side's wait stays high throughout.
- Back-to-back transactions: at least one IDLE cycle between completions; maximum throughput is one access per 2 + RAM latency cycles.
- The latched address is used for the whole grant; requester address changes mid-grant are ignored.
- Reset asserted mid-transaction: immediate return to reset values; the transaction is lost with no wait pulse.
- err clears only on reset.

Test Plan:
- Instruction read:
  - Stimulus: iREN=1, iaddr=0x0000_0040; RAM returns BUSY for 2 cycles then ACCESS with ramload=0x2002_0001.
  - Required: ramREN high from cycle 1; iwait low exactly one cycle with iload=0x2002_0001; FSM back to IDLE.
- Data write:
  - Stimulus: dWEN=1, daddr=0x0000_0100, dstore=0xDEAD_BEEF.
  - Required: ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF until ACCESS; dwait low one cycle; dload=0.
- Simultaneous requests:
  - Stimulus: iREN and dREN both held high from reset.
  - Required: first grant DGRANT (last_grant reset = INSTR), then IGRANT, then DGRANT alternating; neither side starves.
- RAM error:
  - Stimulus: dREN=1, ramstate=ERROR.
  - Required: dwait low one cycle; dload=0; err=1 sticky through later successful accesses.
- Timeout:
  - Stimulus: TIMEOUT=4, iREN=1, ramstate held BUSY.
  - Required: iwait pulses low on the 4th grant cycle; err=1; busy drops next cycle.
- Abort and reset:
  - Stimulus: dREN dropped during BUSY.
  - Required: no dwait pulse, IDLE next cycle, err=0.
  - Stimulus: nRST pulsed mid-grant.
  - Required: all outputs immediately at reset values.
